// File: rtl/pdp8_memory_arbiter.sv
// pdp8_memory_arbiter
//
// Sequences every access to the PDP8 main-memory controller and shares it
// between two requesters: instruction fetch (IF, read-only) and execute
// (EX, read or write). A winning request is latched in IDLE. Each access
// then runs through ISSUE (one enable pulse), CAPTURE (read data registered)
// and RESPOND (one-cycle done strobe to the winner), and the arbiter returns
// to IDLE. Requests are never sampled outside IDLE.
//
// Configuration macro:
//   MEM_ARB_ROUND_ROBIN_EN  defined   : on contention, grant the requester that
//                                       was not served last (first contention
//                                       after reset goes to EX)
//                           undefined : fixed priority, EX always wins
//
// Ports:
//   clk, reset_n                  clock (rising edge), async active-low reset
//   if_req, if_addr, if_done      fetch request / address / completion strobe
//   ex_req, ex_we, ex_addr,
//   ex_wdata, ex_done             execute request / write flag / address /
//                                 write data / completion strobe
//   rdata                         captured read data, valid in the done cycle
//   mem_address, mem_write_data,
//   mem_read_enable,
//   mem_write_enable,
//   mem_read_type, mem_read_data  memory controller interface
//   busy                          high whenever the FSM is not in IDLE
//   access_count                  completed accesses, wraps at all-ones

`ifndef INSTRUCTION_FETCH
`define INSTRUCTION_FETCH 1'b1
`endif
`ifndef DATA_READ
`define DATA_READ 1'b0
`endif

module pdp8_memory_arbiter #(
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   if_req,
  input  logic [11:0]            if_addr,
  output logic                   if_done,
  input  logic                   ex_req,
  input  logic                   ex_we,
  input  logic [11:0]            ex_addr,
  input  logic [11:0]            ex_wdata,
  output logic                   ex_done,
  output logic [11:0]            rdata,
  output logic [11:0]            mem_address,
  output logic [11:0]            mem_write_data,
  output logic                   mem_read_enable,
  output logic                   mem_write_enable,
  output logic                   mem_read_type,
  input  logic [11:0]            mem_read_data,
  output logic                   busy,
  output logic [COUNT_WIDTH-1:0] access_count
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    RESPOND = 2'd3
  } state_t;

  localparam logic GRANT_IF = 1'b0;
  localparam logic GRANT_EX = 1'b1;

  state_t      state;
  state_t      state_next;

  logic        any_req;
  logic        grant_ex;

  logic [11:0] addr_q;
  logic [11:0] wdata_q;
  logic        we_q;
  logic        type_q;
  logic        winner_q;
  logic        last_grant;

  assign any_req = if_req | ex_req;

  // EX is granted when it is the only requester, or when it wins contention.
`ifdef MEM_ARB_ROUND_ROBIN_EN
  assign grant_ex = ex_req & (~if_req | (last_grant == GRANT_IF));
`else
  assign grant_ex = ex_req;

  // last_grant is tracked in both builds but only steers the round-robin one.
  logic unused_last_grant;
  assign unused_last_grant = last_grant;
`endif

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and strobe decode
  always_comb begin
    state_next       = state;
    mem_read_enable  = 1'b0;
    mem_write_enable = 1'b0;
    if_done          = 1'b0;
    ex_done          = 1'b0;
    case (state)
      IDLE: begin
        if (any_req) begin
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        mem_read_enable  = ~we_q;
        mem_write_enable = we_q;
        state_next       = CAPTURE;
      end
      CAPTURE: begin
        state_next = RESPOND;
      end
      RESPOND: begin
        if_done    = (winner_q == GRANT_IF);
        ex_done    = (winner_q == GRANT_EX);
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign busy           = (state != IDLE);
  assign mem_address    = addr_q;
  assign mem_write_data = wdata_q;
  assign mem_read_type  = type_q;

  // Request latch, read-data capture, completion bookkeeping
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_q       <= 12'd0;
      wdata_q      <= 12'd0;
      we_q         <= 1'b0;
      type_q       <= 1'b0;
      winner_q     <= 1'b0;
      last_grant   <= GRANT_IF;
      rdata        <= 12'd0;
      access_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            addr_q   <= grant_ex ? ex_addr : if_addr;
            we_q     <= grant_ex & ex_we;
            type_q   <= grant_ex ? `DATA_READ : `INSTRUCTION_FETCH;
            winner_q <= grant_ex ? GRANT_EX : GRANT_IF;
            if (grant_ex) begin
              wdata_q <= ex_wdata;
            end
          end
        end
        CAPTURE: begin
          // Writes leave the previous read result visible.
          if (!we_q) begin
            rdata <= mem_read_data;
          end
        end
        RESPOND: begin
          access_count <= access_count + COUNT_WIDTH'(1);
          last_grant   <= winner_q;
        end
        default: begin
        end
      endcase
    end
  end

endmodule
